// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg: shared definitions for the 5-stage MIPS core.
//   - opcode constants for the supported instruction subset
//   - ALU-op encodings handed from ID to the EX-stage ALU control
//   - control bundles (EX-visible part plus the ID-only branch flag)
//   - decode_ctrl(): opcode -> control bundle
//   - reg_hit(): nonzero destination matches one of two source registers
// Optional build macro used elsewhere in the core: REGFILE_BYPASS_EN.
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Control bits carried into ID/EX and beyond.
    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic [1:0] alu_op;
    } ex_ctrl_t;

    // Full decode result; branch is consumed inside ID and never registered.
    typedef struct packed {
        ex_ctrl_t ex;
        logic     branch;
    } ctrl_t;

    function automatic ctrl_t decode_ctrl(input logic [5:0] op);
        ctrl_t c;
        c = '0;
        case (op)
            OP_RTYPE: begin
                c.ex.reg_dst   = 1'b1;
                c.ex.reg_write = 1'b1;
                c.ex.alu_op    = ALUOP_FUNCT;
            end
            OP_LW: begin
                c.ex.alu_src    = 1'b1;
                c.ex.mem_read   = 1'b1;
                c.ex.mem_to_reg = 1'b1;
                c.ex.reg_write  = 1'b1;
                c.ex.alu_op     = ALUOP_ADD;
            end
            OP_SW: begin
                c.ex.alu_src   = 1'b1;
                c.ex.mem_write = 1'b1;
                c.ex.alu_op    = ALUOP_ADD;
            end
            OP_BEQ: begin
                c.ex.alu_op = ALUOP_SUB;
                c.branch    = 1'b1;
            end
            OP_ADDI: begin
                c.ex.alu_src   = 1'b1;
                c.ex.reg_write = 1'b1;
                c.ex.alu_op    = ALUOP_ADD;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    // $0 is never a real producer, so a zero destination never matches.
    function automatic logic reg_hit(input logic [4:0] dst,
                                     input logic [4:0] src_a,
                                     input logic [4:0] src_b);
        return (dst != 5'd0) && ((dst == src_a) || (dst == src_b));
    endfunction

endpackage

// File: rtl/reg_file.sv
// -----------------------------------------------------------------------------
// reg_file: architectural register file, 2 combinational reads, 1 sync write.
//   i_clk, i_rst            clock / async active-high reset (clears all regs)
//   i_raddr_a/b, o_rdata_a/b read ports ($0 always reads 0)
//   i_we, i_waddr, i_wdata  write port (writes to $0 are dropped)
// Build macro REGFILE_BYPASS_EN: a read of the register being written this
// cycle returns i_wdata (write-first); otherwise it returns the stored value.
// -----------------------------------------------------------------------------
module reg_file
    import cpu_pkg::*;
#(
    parameter int DW = 32,
    parameter int RN = 32,
    parameter int AW = $clog2(RN)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [AW-1:0] i_raddr_a,
    input  logic [AW-1:0] i_raddr_b,
    output logic [DW-1:0] o_rdata_a,
    output logic [DW-1:0] o_rdata_b,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata
);

    logic [DW-1:0] regs_q [RN];
    logic          wr_en;

    assign wr_en = i_we && (i_waddr != '0);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < RN; i++) regs_q[i] <= '0;
        end else if (wr_en) begin
            regs_q[i_waddr] <= i_wdata;
        end
    end

    always_comb begin
        o_rdata_a = regs_q[i_raddr_a];
        if (i_raddr_a == '0) o_rdata_a = '0;
`ifdef REGFILE_BYPASS_EN
        else if (wr_en && (i_waddr == i_raddr_a)) o_rdata_a = i_wdata;
`endif
    end

    always_comb begin
        o_rdata_b = regs_q[i_raddr_b];
        if (i_raddr_b == '0) o_rdata_b = '0;
`ifdef REGFILE_BYPASS_EN
        else if (wr_en && (i_waddr == i_raddr_b)) o_rdata_b = i_wdata;
`endif
    end

endmodule

// File: rtl/id_stage.sv
// -----------------------------------------------------------------------------
// id_stage: instruction decode stage of the 5-stage MIPS pipeline.
//   Inputs : i_clk, i_rst (async, active high), IF/ID pair (i_next_pc,
//            i_instr), WB write port (i_wb_*), EX/MEM producer (i_mem_*).
//   To IF  : o_pc_src, o_branch_addr, o_stall, o_if_flush (combinational).
//   ID/EX  : o_next_pc, o_rs_data, o_rt_data, o_imm, o_rs/o_rt/o_rd and the
//            control bits, all registered.
// beq is resolved here, so it must wait until any in-flight producer of its
// operands has written back. Build macro REGFILE_BYPASS_EN: with the
// write-first register file the WB-stage producer is already visible, without
// it the beq also waits out the WB stage.
// -----------------------------------------------------------------------------
module id_stage
    import cpu_pkg::*;
#(
    parameter int DW = 32,
    parameter int RN = 32
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [DW-1:0] i_next_pc,
    input  logic [31:0]   i_instr,
    input  logic          i_wb_reg_write,
    input  logic [4:0]    i_wb_rd,
    input  logic [DW-1:0] i_wb_data,
    input  logic          i_mem_reg_write,
    input  logic [4:0]    i_mem_rd,
    output logic          o_pc_src,
    output logic [DW-1:0] o_branch_addr,
    output logic          o_stall,
    output logic          o_if_flush,
    output logic [DW-1:0] o_next_pc,
    output logic [DW-1:0] o_rs_data,
    output logic [DW-1:0] o_rt_data,
    output logic [DW-1:0] o_imm,
    output logic [4:0]    o_rs,
    output logic [4:0]    o_rt,
    output logic [4:0]    o_rd,
    output logic          o_reg_dst,
    output logic          o_alu_src,
    output logic          o_mem_read,
    output logic          o_mem_write,
    output logic          o_mem_to_reg,
    output logic          o_reg_write,
    output logic [1:0]    o_alu_op
);

    typedef struct packed {
        logic [DW-1:0] next_pc;
        logic [DW-1:0] rs_data;
        logic [DW-1:0] rt_data;
        logic [DW-1:0] imm;
        logic [4:0]    rs;
        logic [4:0]    rt;
        logic [4:0]    rd;
        ex_ctrl_t      ctrl;
    } idex_t;

    idex_t         idex_q, idex_d;
    ctrl_t         ctrl;
    logic [4:0]    rs, rt, rd;
    logic [DW-1:0] imm;
    logic [DW-1:0] rs_val, rt_val;
    logic [4:0]    ex_dst;
    logic          load_use, ex_haz, mem_haz, wb_haz, br_haz, stall;

    // Field split and sign extension
    assign rs   = i_instr[25:21];
    assign rt   = i_instr[20:16];
    assign rd   = i_instr[15:11];
    assign imm  = {{(DW-16){i_instr[15]}}, i_instr[15:0]};
    assign ctrl = decode_ctrl(i_instr[31:26]);

    reg_file #(.DW(DW), .RN(RN)) u_rf (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_raddr_a (rs),
        .i_raddr_b (rt),
        .o_rdata_a (rs_val),
        .o_rdata_b (rt_val),
        .i_we      (i_wb_reg_write),
        .i_waddr   (i_wb_rd),
        .i_wdata   (i_wb_data)
    );

    // Hazard detection. Load-use applies to every consumer; the producer
    // checks below only matter for beq, which compares operands in ID.
    assign ex_dst   = idex_q.ctrl.reg_dst ? idex_q.rd : idex_q.rt;
    assign load_use = idex_q.ctrl.mem_read && reg_hit(idex_q.rt, rs, rt);
    assign ex_haz   = idex_q.ctrl.reg_write && reg_hit(ex_dst, rs, rt);
    assign mem_haz  = i_mem_reg_write && reg_hit(i_mem_rd, rs, rt);
`ifdef REGFILE_BYPASS_EN
    assign wb_haz   = 1'b0;
`else
    assign wb_haz   = i_wb_reg_write && reg_hit(i_wb_rd, rs, rt);
`endif
    assign br_haz   = ctrl.branch && (ex_haz || mem_haz || wb_haz);
    assign stall    = load_use || br_haz;

    // A stalled beq must not redirect fetch; it is re-evaluated next cycle.
    assign o_stall       = stall;
    assign o_pc_src      = ctrl.branch && (rs_val == rt_val) && !stall;
    assign o_if_flush    = o_pc_src;
    assign o_branch_addr = i_next_pc + {imm[DW-3:0], 2'b00};

    always_comb begin
        idex_d = '0;
        if (!stall) begin
            idex_d.next_pc = i_next_pc;
            idex_d.rs_data = rs_val;
            idex_d.rt_data = rt_val;
            idex_d.imm     = imm;
            idex_d.rs      = rs;
            idex_d.rt      = rt;
            idex_d.rd      = rd;
            idex_d.ctrl    = ctrl.ex;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) idex_q <= '0;
        else       idex_q <= idex_d;
    end

    assign o_next_pc    = idex_q.next_pc;
    assign o_rs_data    = idex_q.rs_data;
    assign o_rt_data    = idex_q.rt_data;
    assign o_imm        = idex_q.imm;
    assign o_rs         = idex_q.rs;
    assign o_rt         = idex_q.rt;
    assign o_rd         = idex_q.rd;
    assign o_reg_dst    = idex_q.ctrl.reg_dst;
    assign o_alu_src    = idex_q.ctrl.alu_src;
    assign o_mem_read   = idex_q.ctrl.mem_read;
    assign o_mem_write  = idex_q.ctrl.mem_write;
    assign o_mem_to_reg = idex_q.ctrl.mem_to_reg;
    assign o_reg_write  = idex_q.ctrl.reg_write;
    assign o_alu_op     = idex_q.ctrl.alu_op;

endmodule

// File: tb/tb_id_stage.sv
// -----------------------------------------------------------------------------
// tb_id_stage: self-checking bench for id_stage. A table of decode vectors
// plus hand-written hazard / bypass / reset sequences. Expected ID/EX contents
// are queued when an instruction is presented and compared after the edge.
// Honours REGFILE_BYPASS_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_id_stage;
    import cpu_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [31:0] i_next_pc, i_instr, i_wb_data;
    logic        i_wb_reg_write, i_mem_reg_write;
    logic [4:0]  i_wb_rd, i_mem_rd;
    logic        o_pc_src, o_stall, o_if_flush;
    logic [31:0] o_branch_addr, o_next_pc, o_rs_data, o_rt_data, o_imm;
    logic [4:0]  o_rs, o_rt, o_rd;
    logic        o_reg_dst, o_alu_src, o_mem_read, o_mem_write, o_mem_to_reg, o_reg_write;
    logic [1:0]  o_alu_op;

    id_stage dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_next_pc(i_next_pc), .i_instr(i_instr),
        .i_wb_reg_write(i_wb_reg_write), .i_wb_rd(i_wb_rd), .i_wb_data(i_wb_data),
        .i_mem_reg_write(i_mem_reg_write), .i_mem_rd(i_mem_rd),
        .o_pc_src(o_pc_src), .o_branch_addr(o_branch_addr), .o_stall(o_stall),
        .o_if_flush(o_if_flush), .o_next_pc(o_next_pc), .o_rs_data(o_rs_data),
        .o_rt_data(o_rt_data), .o_imm(o_imm), .o_rs(o_rs), .o_rt(o_rt), .o_rd(o_rd),
        .o_reg_dst(o_reg_dst), .o_alu_src(o_alu_src), .o_mem_read(o_mem_read),
        .o_mem_write(o_mem_write), .o_mem_to_reg(o_mem_to_reg),
        .o_reg_write(o_reg_write), .o_alu_op(o_alu_op)
    );

    always #5 i_clk = ~i_clk;

    // {reg_dst, alu_src, mem_read, mem_write, mem_to_reg, reg_write, alu_op}
    localparam logic [7:0] C_R    = 8'b1000_0110;
    localparam logic [7:0] C_LW   = 8'b0110_1100;
    localparam logic [7:0] C_SW   = 8'b0101_0000;
    localparam logic [7:0] C_BEQ  = 8'b0000_0001;
    localparam logic [7:0] C_ADDI = 8'b0100_0100;
    localparam logic [7:0] C_NONE = 8'b0000_0000;
    localparam logic [31:0] NOP_I = 32'hFC00_0000;

    typedef struct packed {
        logic [31:0] next_pc, rs_data, rt_data, imm;
        logic [4:0]  rs, rt, rd;
        logic [7:0]  ctrl;
    } idex_t;

    typedef struct {
        logic [31:0] instr, pc;
        logic        stall, pc_src, chk_ba;
        logic [31:0] ba;
        idex_t       exp;
    } vec_t;

    int    errors = 0;
    int    checks = 0;
    idex_t sb[$];
    vec_t  vecs[9];

    function automatic logic [31:0] rtype(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
        return {OP_RTYPE, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, rt,
                                          input logic [15:0] im);
        return {op, rs, rt, im};
    endfunction

    function automatic idex_t mk(input logic [31:0] instr, pc, rsd, rtd, input logic [7:0] c);
        idex_t e;
        e.next_pc = pc;
        e.rs_data = rsd;
        e.rt_data = rtd;
        e.imm     = {{16{instr[15]}}, instr[15:0]};
        e.rs      = instr[25:21];
        e.rt      = instr[20:16];
        e.rd      = instr[15:11];
        e.ctrl    = c;
        return e;
    endfunction

    function automatic vec_t V(input logic [31:0] instr, pc, input logic st, ps, cb,
                               input logic [31:0] ba, rsd, rtd, input logic [7:0] c);
        vec_t v;
        v.instr = instr; v.pc = pc; v.stall = st; v.pc_src = ps; v.chk_ba = cb; v.ba = ba;
        v.exp = st ? idex_t'('0) : mk(instr, pc, rsd, rtd, c);
        return v;
    endfunction

    function automatic idex_t act_idex();
        return {o_next_pc, o_rs_data, o_rt_data, o_imm, o_rs, o_rt, o_rd,
                o_reg_dst, o_alu_src, o_mem_read, o_mem_write, o_mem_to_reg,
                o_reg_write, o_alu_op};
    endfunction

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present one IF/ID instruction, check the combinational outputs before
    // the edge, queue the expected ID/EX image and compare it after the edge.
    task automatic drive_cycle(input string tag, input logic [31:0] instr, pc,
                               input logic e_stall, e_pcsrc, chk_ba,
                               input logic [31:0] e_ba, input idex_t e_idex);
        idex_t exp;
        @(negedge i_clk);
        i_instr   = instr;
        i_next_pc = pc;
        #1;
        chk({tag, "/stall"},    160'(o_stall),    160'(e_stall));
        chk({tag, "/pc_src"},   160'(o_pc_src),   160'(e_pcsrc));
        chk({tag, "/if_flush"}, 160'(o_if_flush), 160'(e_pcsrc));
        if (chk_ba) chk({tag, "/branch_addr"}, 160'(o_branch_addr), 160'(e_ba));
        sb.push_back(e_idex);
        @(posedge i_clk);
        #1;
        if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s/scoreboard: queue empty", tag);
        end else begin
            exp = sb.pop_front();
            chk({tag, "/idex"}, 160'(act_idex()), 160'(exp));
        end
    endtask

    task automatic wb_write(input logic [4:0] r, input logic [31:0] d);
        @(negedge i_clk);
        i_instr = NOP_I; i_next_pc = '0;
        i_wb_reg_write = 1'b1; i_wb_rd = r; i_wb_data = d;
        @(posedge i_clk);
        #1;
        i_wb_reg_write = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] ins;
        i_rst = 1'b1; i_next_pc = '0; i_instr = '0; i_wb_data = '0;
        i_wb_reg_write = 1'b0; i_wb_rd = '0; i_mem_reg_write = 1'b0; i_mem_rd = '0;
        #2;
        chk("reset/idex",     160'(act_idex()), 160'(0));
        chk("reset/stall",    160'(o_stall),    160'(0));
        chk("reset/pc_src",   160'(o_pc_src),   160'(0));
        chk("reset/if_flush", 160'(o_if_flush), 160'(0));
        @(negedge i_clk);
        i_rst = 1'b0;

        wb_write(5'd1, 32'd7);
        wb_write(5'd2, 32'd7);
        wb_write(5'd3, 32'h10);
        wb_write(5'd9, 32'h55);
        wb_write(5'd5, 32'h1234);

        vecs[0] = V(rtype(5, 0, 3, 6'h20),           32'h10, 0, 0, 0, 0, 32'h1234, 0, C_R);
        vecs[1] = V(itype(OP_LW, 1, 6, 16'hFFFC),    32'h14, 0, 0, 0, 0, 7, 0, C_LW);
        vecs[2] = V(itype(OP_SW, 9, 5, 16'd8),       32'h18, 0, 0, 0, 0, 32'h55, 32'h1234, C_SW);
        vecs[3] = V(itype(OP_ADDI, 0, 7, 16'd5),     32'h1C, 0, 0, 0, 0, 0, 0, C_ADDI);
        vecs[4] = V(itype(6'h3F, 1, 2, 16'h1234),    32'h20, 0, 0, 0, 0, 7, 7, C_NONE);
        vecs[5] = V(itype(OP_BEQ, 1, 2, 16'd3),      32'h100, 0, 1, 1, 32'h10C, 7, 7, C_BEQ);
        vecs[6] = V(itype(OP_BEQ, 1, 9, 16'hFFFF),   32'h100, 0, 0, 1, 32'hFC, 7, 32'h55, C_BEQ);
        vecs[7] = V(itype(OP_BEQ, 2, 1, 16'd1),      32'hFFFF_FFFC, 0, 1, 1, 32'h0, 7, 7, C_BEQ);
        vecs[8] = V(itype(OP_BEQ, 0, 0, 16'h7FFF),   32'h200, 0, 1, 1, 32'h201FC, 0, 0, C_BEQ);
        for (int i = 0; i < 9; i++)
            drive_cycle($sformatf("vec%0d", i), vecs[i].instr, vecs[i].pc, vecs[i].stall,
                        vecs[i].pc_src, vecs[i].chk_ba, vecs[i].ba, vecs[i].exp);

        // Load-use: one bubble, then the consumer issues.
        ins = itype(OP_LW, 1, 2, 16'd4);
        drive_cycle("lu/lw", ins, 32'h30, 0, 0, 0, 0, mk(ins, 32'h30, 7, 7, C_LW));
        ins = rtype(2, 3, 4, 6'h20);
        drive_cycle("lu/stall", ins, 32'h34, 1, 0, 0, 0, '0);
        drive_cycle("lu/issue", ins, 32'h34, 0, 0, 0, 0, mk(ins, 32'h34, 7, 32'h10, C_R));

        // Unequal operands: not taken.
        wb_write(5'd2, 32'd8);
        ins = itype(OP_BEQ, 1, 2, 16'd3);
        drive_cycle("beq_ne", ins, 32'h100, 0, 0, 1, 32'h10C, mk(ins, 32'h100, 7, 8, C_BEQ));

        // addi -> beq: stall while the producer sits in EX, then MEM (and WB
        // without the write-first register file).
        ins = itype(OP_ADDI, 0, 1, 16'd5);
        drive_cycle("br/addi", ins, 32'h40, 0, 0, 0, 0, mk(ins, 32'h40, 0, 7, C_ADDI));
        ins = itype(OP_BEQ, 1, 0, 16'd2);
        drive_cycle("br/ex", ins, 32'h44, 1, 0, 0, 0, '0);
        i_mem_reg_write = 1'b1; i_mem_rd = 5'd1;
        drive_cycle("br/mem", ins, 32'h44, 1, 0, 0, 0, '0);
        i_mem_reg_write = 1'b0; i_wb_reg_write = 1'b1; i_wb_rd = 5'd1; i_wb_data = 32'd5;
`ifdef REGFILE_BYPASS_EN
        drive_cycle("br/go", ins, 32'h44, 0, 0, 1, 32'h4C, mk(ins, 32'h44, 5, 0, C_BEQ));
        i_wb_reg_write = 1'b0;
`else
        drive_cycle("br/wb", ins, 32'h44, 1, 0, 0, 0, '0);
        i_wb_reg_write = 1'b0;
        drive_cycle("br/go", ins, 32'h44, 0, 0, 1, 32'h4C, mk(ins, 32'h44, 5, 0, C_BEQ));
`endif

        // Equal operands under a stall: stall wins, branch taken afterwards.
        ins = itype(OP_BEQ, 2, 2, 16'd4);
        i_mem_reg_write = 1'b1; i_mem_rd = 5'd2;
        drive_cycle("stallwin/hold", ins, 32'h80, 1, 0, 0, 0, '0);
        i_mem_reg_write = 1'b0;
        drive_cycle("stallwin/take", ins, 32'h80, 0, 1, 1, 32'h90, mk(ins, 32'h80, 8, 8, C_BEQ));

        // Same-cycle write and read of $9, then a write to $0.
        ins = rtype(9, 0, 10, 6'h20);
        i_wb_reg_write = 1'b1; i_wb_rd = 5'd9; i_wb_data = 32'hAA;
`ifdef REGFILE_BYPASS_EN
        drive_cycle("byp/same", ins, 32'h50, 0, 0, 0, 0, mk(ins, 32'h50, 32'hAA, 0, C_R));
`else
        drive_cycle("byp/same", ins, 32'h50, 0, 0, 0, 0, mk(ins, 32'h50, 32'h55, 0, C_R));
`endif
        i_wb_reg_write = 1'b0;
        drive_cycle("byp/after", ins, 32'h54, 0, 0, 0, 0, mk(ins, 32'h54, 32'hAA, 0, C_R));
        ins = rtype(0, 9, 10, 6'h20);
        i_wb_reg_write = 1'b1; i_wb_rd = 5'd0; i_wb_data = 32'hFFFF;
        drive_cycle("r0/same", ins, 32'h58, 0, 0, 0, 0, mk(ins, 32'h58, 0, 32'hAA, C_R));
        i_wb_reg_write = 1'b0;
        drive_cycle("r0/after", ins, 32'h5C, 0, 0, 0, 0, mk(ins, 32'h5C, 0, 32'hAA, C_R));

        // Reset in the middle of a load-use stall.
        ins = itype(OP_LW, 1, 2, 16'd4);
        drive_cycle("rst/lw", ins, 32'h60, 0, 0, 0, 0, mk(ins, 32'h60, 5, 8, C_LW));
        @(negedge i_clk);
        i_instr = rtype(2, 3, 4, 6'h20); i_next_pc = 32'h64;
        #1;
        chk("rst/pre_stall", 160'(o_stall), 160'(1));
        #1;
        i_rst = 1'b1;
        #1;
        chk("rst/idex",  160'(act_idex()), 160'(0));
        chk("rst/stall", 160'(o_stall),    160'(0));
        @(negedge i_clk);
        i_rst = 1'b0;
        ins = rtype(2, 3, 4, 6'h20);
        drive_cycle("rst/clean", ins, 32'h64, 0, 0, 0, 0, mk(ins, 32'h64, 0, 0, C_R));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_stage.md
# id_stage

Instruction-decode stage of the 5-stage pipelined MIPS core, directly downstream of the fetch stage. It consumes the IF/ID pair (PC+4, instruction), reads the 32×32 register file, decodes control, and resolves `beq` early. It feeds the branch target and PC-select back to fetch and detects load-use and branch data hazards. It registers everything into the ID/EX pipeline register.

## Interface
Parameters:
- `DW`, 32, datapath width
- `RN`, 32, number of architectural registers

Ports:
- `i_clk` in 1: clock, rising edge
- `i_rst` in 1: asynchronous, active-high reset
- `i_next_pc` in 32: PC+4 from IF/ID
- `i_instr` in 32: instruction from IF/ID
- `i_wb_reg_write` in 1: WB-stage write enable
- `i_wb_rd` in 5: WB destination register
- `i_wb_data` in 32: WB write data
- `i_mem_reg_write` in 1: EX/MEM reg_write
- `i_mem_rd` in 5: EX/MEM destination register
- `o_pc_src` out 1: take branch (to IF mux)
- `o_branch_addr` out 32: `i_next_pc + (sext(imm16) << 2)`
- `o_stall` out 1: hold PC and IF/ID
- `o_if_flush` out 1: zero IF/ID on the next edge
- ID/EX outputs, all registered:
  - `o_next_pc` 32
  - `o_rs_data` 32
  - `o_rt_data` 32
  - `o_imm` 32 (sign-extended)
  - `o_rs`, `o_rt`, `o_rd` 5 each
  - `o_reg_dst`, `o_alu_src`, `o_mem_read`, `o_mem_write`, `o_mem_to_reg`, `o_reg_write` 1 each
  - `o_alu_op` 2

## Operation
- Decode uses `op = instr[31:26]`.
  - R-type `000000`: reg_dst=1, reg_write=1, alu_op=10
  - lw `100011`: alu_src=1, mem_read=1, mem_to_reg=1, reg_write=1, alu_op=00
  - sw `101011`: alu_src=1, mem_write=1, alu_op=00
  - beq `000100`: alu_op=01, branch=1
  - addi `001000`: alu_src=1, reg_write=1, alu_op=00
  - Any other opcode: all controls 0 (NOP).
- Register file:
  - Two combinational read ports, one synchronous write port.
  - Writes on the rising edge when `i_wb_reg_write && i_wb_rd != 0`.
  - `$0` always reads 0.
- Load-use hazard: `o_stall=1` when the ID/EX stage holds a load (`o_mem_read`) with `o_rt != 0` and `o_rt` equals the decoded rs or rt.
- Branch hazard: when the decoded instruction is beq, `o_stall=1` if either of these matches rs or rt (nonzero destination):
  - the ID/EX stage's `o_reg_write` with destination `o_reg_dst ? o_rd : o_rt`
  - `i_mem_reg_write` with `i_mem_rd`
- Branch resolution: `o_pc_src = branch & (rs_val == rt_val) & ~o_stall`, combinational. `o_if_flush = o_pc_src`.
- On stall:
  - ID/EX loads a bubble: all control bits 0, data fields don't-care but driven 0.
  - The IF/ID contents are held externally, so the same instruction is re-decoded next cycle.
- Stall and branch in the same cycle: the stall wins; the branch is evaluated again after the stall clears.
- A taken branch still loads the beq itself into ID/EX. It is harmless, since it has no reg_write and no mem_write.

## Timing
- Reset (asynchronous, immediate):
  - all ID/EX outputs go to 0
  - all registers in the file go to 0
  - `o_stall`, `o_pc_src`, `o_if_flush` follow combinationally from the zeroed state, which is 0 for an all-zero instruction
- ID/EX latency is 1 cycle from the IF/ID values.
- `o_pc_src`, `o_branch_addr`, `o_stall` are combinational in the same cycle.
- Load-use stall lasts exactly 1 cycle.
- Branch stall lasts 1 or 2 cycles, until the producer has left both EX and MEM.
- Reset asserted mid-stall aborts it; the next decode after deassertion starts clean.
- `o_branch_addr` addition wraps modulo 2^32.

## Configuration
- `REGFILE_BYPASS_EN` defined: a read of the register being written in the same cycle (`i_wb_reg_write`, nonzero `i_wb_rd` match) returns `i_wb_data` (write-first). This also applies to the beq compare.
- `REGFILE_BYPASS_EN` undefined: the read returns the old value. The WB-stage hazard is then also checked for beq, so the branch stall extends one more cycle.

## Structure
- Shared package `cpu_pkg`:
  - opcode constants (`OP_RTYPE`, `OP_LW`, `OP_SW`, `OP_BEQ`, `OP_ADDI`)
  - ALU-op encodings (`ALUOP_ADD=2'b00`, `ALUOP_SUB=2'b01`, `ALUOP_FUNCT=2'b10`)
  - a control-bundle struct
- One sub-module, `reg_file` (2R1W, `$0` hardwired, bypass under the macro). Decode, hazard logic and the ID/EX register stay in `id_stage`.

## Test plan
- Reset, then WB writes 0x1234 to `$5`; on the next cycle decode `add $3,$5,$0` → `o_rs_data=0x1234`, reg_dst=1, alu_op=10, reg_write=1.
- `lw $2,4($1)` followed by `add $4,$2,$3` → `o_stall=1` for one cycle. ID/EX holds a bubble (all controls 0), then the add issues.
- beq with `$1=$2=7`, `i_next_pc=0x100`, imm=3 → `o_pc_src=1`, `o_branch_addr=0x10C`, `o_if_flush=1`. With `$2=8` → `o_pc_src=0`.
- `addi $1,$0,5` then `beq $1,$0,x` → stall 2 cycles (EX then MEM), then `o_pc_src=0`.
- WB writes `$9=0xAA` in the same cycle `$9` is read → 0xAA with `REGFILE_BYPASS_EN`, old value without it. A write to `$0` leaves it reading 0.
- Assert `i_rst` mid-stall → all ID/EX outputs 0 immediately and `o_stall=0`.
